// File: rtl/fp16_pkg.sv
// rtl/fp16_pkg.sv - shared FP16 types and constants for the FFT datapath
package fp16_pkg;

    localparam int EXP_W   = 5;
    localparam int FRA_W   = 10;
    localparam int BIAS    = 15;
    localparam int EXP_MAX = 31;
    localparam int MAN_W   = FRA_W + 1;
    localparam logic [15:0] QNAN = 16'h7e00;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [FRA_W-1:0] fra;
    } fp16_t;

    typedef struct packed {
        logic overflow;
        logic zero;
        logic nan;
        logic precision_lost;
    } fp16_flags_t;

    typedef enum logic [1:0] {
        SP_NONE,
        SP_NAN,
        SP_INF,
        SP_ZERO
    } special_e;

endpackage

// File: rtl/fp16_classify.sv
// rtl/fp16_classify.sv - combinational FP16 operand classifier
module fp16_classify
    import fp16_pkg::*;
(
    input  fp16_t            num,
    output logic             sign,
    output logic             is_zero,
    output logic             is_inf,
    output logic             is_nan,
    output logic [MAN_W-1:0] mant
);

    logic exp_all_ones;

    always_comb begin
        sign         = num.sign;
        exp_all_ones = &num.exp;
        // Subnormals are flushed: any zero exponent counts as zero.
        is_zero      = (num.exp == '0);
        is_inf       = exp_all_ones && (num.fra == '0);
        is_nan       = exp_all_ones && (num.fra != '0);
        mant         = is_zero ? '0 : {1'b1, num.fra};
    end

endmodule

// File: rtl/fp16_mult_pipe.sv
// rtl/fp16_mult_pipe.sv - pipelined FP16 multiplier with valid/ready handshake
module fp16_mult_pipe #(
    parameter int EXP_W = 5,
    parameter int FRA_W = 10,
    parameter int BIAS  = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+FRA_W:0]   num1,
    input  logic [EXP_W+FRA_W:0]   num2,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+FRA_W:0]   result,
    output logic                   overflow,
    output logic                   zero,
    output logic                   nan,
    output logic                   precisionLost
);
    import fp16_pkg::*;

    localparam int M_W = FRA_W + 1;
    localparam int P_W = 2 * M_W;
    localparam int E_W = EXP_W + 2;
    localparam logic signed [E_W-1:0] EMAX = E_W'((1 << EXP_W) - 1);

    logic advance;

    // Operand capture bank
    logic  a_valid_q, a_valid_d;
    fp16_t a_num1_q, a_num1_d, a_num2_q, a_num2_d;

    // Stage 1 -> 2 bank
    logic                  b_valid_q, b_valid_d, b_sign_q, b_sign_d;
    logic signed [E_W-1:0] b_exp_q, b_exp_d;
    special_e              b_special_q, b_special_d;
    logic [M_W-1:0]        b_m1_q, b_m1_d, b_m2_q, b_m2_d;

    // Stage 2 -> 3 bank
    logic                  c_valid_q, c_valid_d, c_sign_q, c_sign_d;
    logic signed [E_W-1:0] c_exp_q, c_exp_d;
    special_e              c_special_q, c_special_d;
    logic [P_W-1:0]        c_prod_q, c_prod_d;

    // Output bank
    logic        out_valid_q, out_valid_d;
    fp16_t       result_q, result_d;
    fp16_flags_t flags_q, flags_d;

    logic           s1, s2, z1, z2, i1, i2, n1, n2;
    logic [M_W-1:0] m1, m2;

    fp16_classify u_cls1 (
        .num(a_num1_q), .sign(s1), .is_zero(z1), .is_inf(i1), .is_nan(n1), .mant(m1)
    );
    fp16_classify u_cls2 (
        .num(a_num2_q), .sign(s2), .is_zero(z2), .is_inf(i2), .is_nan(n2), .mant(m2)
    );

    assign advance  = !out_valid_q || out_ready;
    assign in_ready = advance;

    always_comb begin
        a_valid_d = in_valid;
        a_num1_d  = in_valid ? fp16_t'(num1) : a_num1_q;
        a_num2_d  = in_valid ? fp16_t'(num2) : a_num2_q;
    end

    always_comb begin
        b_valid_d = a_valid_q;
        b_sign_d  = s1 ^ s2;
        b_exp_d   = $signed({2'b00, a_num1_q.exp}) + $signed({2'b00, a_num2_q.exp})
                    - $signed(E_W'(BIAS));
        b_m1_d    = m1;
        b_m2_d    = m2;
        // NaN outranks infinity, which outranks zero; 0 x inf is NaN.
        if (n1 || n2 || (z1 && i2) || (i1 && z2)) begin
            b_special_d = SP_NAN;
        end else if (i1 || i2) begin
            b_special_d = SP_INF;
        end else if (z1 || z2) begin
            b_special_d = SP_ZERO;
        end else begin
            b_special_d = SP_NONE;
        end
    end

    always_comb begin
        c_valid_d   = b_valid_q;
        c_sign_d    = b_sign_q;
        c_exp_d     = b_exp_q;
        c_special_d = b_special_q;
        c_prod_d    = P_W'(b_m1_q) * P_W'(b_m2_q);
    end

    logic signed [E_W-1:0] e_norm;
    logic [FRA_W-1:0]      fra;
    logic                  lost;

    always_comb begin
        out_valid_d = c_valid_q;
        result_d    = '0;
        flags_d     = '0;
        if (c_prod_q[P_W-1]) begin
            fra    = c_prod_q[P_W-2 -: FRA_W];
            lost   = |c_prod_q[M_W-1:0];
            e_norm = c_exp_q + E_W'(1);
        end else begin
            fra    = c_prod_q[P_W-3 -: FRA_W];
            lost   = |c_prod_q[M_W-2:0];
            e_norm = c_exp_q;
        end
        case (c_special_q)
            SP_NAN: begin
                result_d    = QNAN;
                flags_d.nan = 1'b1;
            end
            SP_INF: begin
                result_d         = {c_sign_q, {EXP_W{1'b1}}, {FRA_W{1'b0}}};
                flags_d.overflow = 1'b1;
            end
            SP_ZERO: begin
                result_d     = {c_sign_q, {(EXP_W+FRA_W){1'b0}}};
                flags_d.zero = 1'b1;
            end
            default: begin
                if (e_norm >= EMAX) begin
                    result_d         = {c_sign_q, {EXP_W{1'b1}}, {FRA_W{1'b0}}};
                    flags_d.overflow = 1'b1;
                end else if (e_norm[E_W-1] || e_norm == '0) begin
                    result_d               = {c_sign_q, {(EXP_W+FRA_W){1'b0}}};
                    flags_d.zero           = 1'b1;
                    flags_d.precision_lost = 1'b1;
                end else begin
                    result_d               = {c_sign_q, e_norm[EXP_W-1:0], fra};
                    flags_d.precision_lost = lost;
                end
            end
        endcase
    end

    // The whole pipeline moves as one rigid unit; a stall freezes every bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid_q   <= 1'b0;
            a_num1_q    <= '0;
            a_num2_q    <= '0;
            b_valid_q   <= 1'b0;
            b_sign_q    <= 1'b0;
            b_exp_q     <= '0;
            b_special_q <= SP_NONE;
            b_m1_q      <= '0;
            b_m2_q      <= '0;
            c_valid_q   <= 1'b0;
            c_sign_q    <= 1'b0;
            c_exp_q     <= '0;
            c_special_q <= SP_NONE;
            c_prod_q    <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
        end else if (advance) begin
            a_valid_q   <= a_valid_d;
            a_num1_q    <= a_num1_d;
            a_num2_q    <= a_num2_d;
            b_valid_q   <= b_valid_d;
            b_sign_q    <= b_sign_d;
            b_exp_q     <= b_exp_d;
            b_special_q <= b_special_d;
            b_m1_q      <= b_m1_d;
            b_m2_q      <= b_m2_d;
            c_valid_q   <= c_valid_d;
            c_sign_q    <= c_sign_d;
            c_exp_q     <= c_exp_d;
            c_special_q <= c_special_d;
            c_prod_q    <= c_prod_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign result        = result_q;
    assign overflow      = flags_q.overflow;
    assign zero          = flags_q.zero;
    assign nan           = flags_q.nan;
    assign precisionLost = flags_q.precision_lost;

endmodule
